// File: rtl/na_sweep_master.sv
// Sweep sequencer for the IQ block. Each point writes the phase increment, polls until
// averaging finishes, reads the I/Q sums and queues them in a first-word-fall-through FIFO.
module na_sweep_master #(
   parameter int PHASEBITS = 32,
   parameter int POINTBITS = 16,
   parameter int FIFO_LOG2 = 4,
   parameter int TIMEOUT   = 1023,
   parameter int POLL_GAP  = 15
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [PHASEBITS-1:0] start_freq_i,
   input  logic [PHASEBITS-1:0] step_freq_i,
   input  logic [POINTBITS-1:0] points_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [15:0]          addr_o,
   output logic                 wen_o,
   output logic                 ren_o,
   output logic [31:0]          wdata_o,
   input  logic                 ack_i,
   input  logic [31:0]          rdata_i,
   output logic                 res_valid_o,
   input  logic                 res_ready_i,
   output logic [POINTBITS-1:0] res_idx_o,
   output logic [61:0]          res_i_o,
   output logic [61:0]          res_q_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_WR_FREQ, S_GAP, S_POLL, S_RD144, S_RD148, S_RD14C, S_PUSH
   } state_t;

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int EW    = POINTBITS + 124;
   localparam int TW    = $clog2(TIMEOUT + 1);
   localparam int GW    = $clog2(POLL_GAP + 1);

   state_t                 state, state_nx;
   logic                   pending;
   logic [TW-1:0]          tcnt;
   logic [GW-1:0]          gcnt;
   logic [PHASEBITS-1:0]   freq, step;
   logic [POINTBITS-1:0]   points, idx;
   logic [30:0]            i_lo, i_hi, q_lo, q_hi;
   logic                   err_q, done_q;
   logic [EW-1:0]          mem [DEPTH];
   logic [FIFO_LOG2-1:0]   wr_ptr, rd_ptr;
   logic [FIFO_LOG2:0]     count;
   logic [EW-1:0]          head;
   logic                   bus_st, strobe, ack_ok, tmo, start_ok;
   logic                   push, pop, last, full, empty;

   // NOTE: every signal written in a combinational block gets a value first, so no latch can form.
   always_comb begin
      bus_st   = state inside {S_WR_FREQ, S_POLL, S_RD144, S_RD148, S_RD14C};
      strobe   = bus_st && !pending;
      ack_ok   = pending && ack_i;
      tmo      = pending && !ack_i && !abort_i && (tcnt == TW'(TIMEOUT - 1));
      start_ok = (state == S_IDLE) && start_i && !abort_i;
      full     = (count == (FIFO_LOG2 + 1)'(DEPTH));
      empty    = (count == '0);
      push     = (state == S_PUSH) && !full && !abort_i;
      pop      = !empty && res_ready_i;
      last     = (POINTBITS'(idx + 1'b1) == points);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state != S_IDLE && abort_i) state_nx = S_IDLE;
      else if (tmo)                   state_nx = S_IDLE;
      else begin
         case (state)
            S_IDLE:    if (start_ok && points_i != '0) state_nx = S_WR_FREQ;
            S_WR_FREQ: if (ack_ok) state_nx = S_POLL;
            S_GAP:     if (gcnt == GW'(POLL_GAP - 1)) state_nx = S_POLL;
            S_POLL:    if (ack_ok) state_nx = rdata_i[31] ? S_GAP : S_RD144;
            S_RD144:   if (ack_ok) state_nx = S_RD148;
            S_RD148:   if (ack_ok) state_nx = S_RD14C;
            S_RD14C:   if (ack_ok) state_nx = S_PUSH;
            S_PUSH:    if (push) state_nx = last ? S_IDLE : S_WR_FREQ;
            default:   state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o  = (state != S_IDLE);
      wen_o   = strobe && (state == S_WR_FREQ);
      ren_o   = strobe && (state != S_WR_FREQ);
      addr_o  = '0;
      wdata_o = '0;
      case (state)
         S_WR_FREQ: begin addr_o = 16'h0108; wdata_o = 32'(freq); end
         S_POLL:    addr_o = 16'h0140;
         S_RD144:   addr_o = 16'h0144;
         S_RD148:   addr_o = 16'h0148;
         S_RD14C:   addr_o = 16'h014C;
         default:   ;
      endcase
   end

   // Timeout counts the strobe cycle itself, so an ack is accepted in cycles 1..TIMEOUT-1 after it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pending <= 1'b0;  tcnt <= '0;  gcnt <= '0;
         freq    <= '0;    step <= '0;  points <= '0;  idx <= '0;
         i_lo    <= '0;    i_hi <= '0;  q_lo <= '0;    q_hi <= '0;
         err_q   <= 1'b0;  done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_ok) begin
            freq   <= start_freq_i;
            step   <= step_freq_i;
            points <= points_i;
            idx    <= '0;
            err_q  <= 1'b0;
            done_q <= (points_i == '0);
         end
         if (tmo) err_q <= 1'b1;
         if (abort_i || tmo || ack_ok) pending <= 1'b0;
         else if (strobe) begin
            pending <= 1'b1;
            tcnt    <= TW'(1);
         end else if (pending) tcnt <= tcnt + 1'b1;
         gcnt <= (state == S_GAP) ? gcnt + 1'b1 : '0;
         if (ack_ok && !abort_i) begin
            case (state)
               S_POLL:  if (!rdata_i[31]) i_lo <= rdata_i[30:0];
               S_RD144: i_hi <= rdata_i[30:0];
               S_RD148: q_lo <= rdata_i[30:0];
               S_RD14C: q_hi <= rdata_i[30:0];
               default: ;
            endcase
         end
         if (push) begin
            freq <= freq + step;
            idx  <= idx + 1'b1;
            if (last) done_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;  rd_ptr <= '0;  count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: the FIFO storage has no reset; emptiness is tracked by count and the outputs are gated by it.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= {idx, i_hi, i_lo, q_hi, q_lo};
   end

   assign head        = mem[rd_ptr];
   assign res_valid_o = !empty;
   assign res_idx_o   = empty ? '0 : head[EW-1 -: POINTBITS];
   assign res_i_o     = empty ? '0 : head[123:62];
   assign res_q_o     = empty ? '0 : head[61:0];
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_na_sweep_master.sv
// Randomized bench for na_sweep_master: a register-slave model answers the bus and a
// scoreboard compares every popped FIFO entry with the sweep expected from the slave data.
module tb_na_sweep_master;
   localparam int TIMEOUT  = 1023;
   localparam int POLL_GAP = 15;

   logic        clk_i = 1'b0;
   logic        rst_i, start_i, abort_i;
   logic [31:0] start_freq_i, step_freq_i;
   logic [15:0] points_i;
   logic        busy_o, done_o, err_o, wen_o, ren_o, ack_i;
   logic [15:0] addr_o;
   logic [31:0] wdata_o, rdata_i;
   logic        res_valid_o, res_ready_i;
   logic [15:0] res_idx_o;
   logic [61:0] res_i_o, res_q_o;

   always #5 clk_i = ~clk_i;

   na_sweep_master #(.TIMEOUT(TIMEOUT), .POLL_GAP(POLL_GAP)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .start_freq_i(start_freq_i), .step_freq_i(step_freq_i), .points_i(points_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .addr_o(addr_o),
      .wen_o(wen_o), .ren_o(ren_o), .wdata_o(wdata_o), .ack_i(ack_i), .rdata_i(rdata_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_idx_o(res_idx_o),
      .res_i_o(res_i_o), .res_q_o(res_q_o)
   );

   typedef struct {
      logic [15:0] idx;
      logic [61:0] i;
      logic [61:0] q;
   } ent_t;

   ent_t        exp_q[$];
   logic [31:0] exp_wr[$];
   logic [31:0] wr_log[$];
   int          n_tests = 0, n_fail = 0;

   // slave model state
   logic [31:0] sl_regs [32][4];
   int          sl_busy [32];
   int          sl_pt = 0, sl_polls_left = 0, sl_pend = 0, sl_lat = 1;
   int          sl_mute_at = 0, sl_strobes = 0, sl_wr_cnt = 0;
   logic [31:0] sl_pend_data = '0;

   int          rdy_mode = 2;
   int          done_cnt = 0, pop_cnt = 0;
   bit          capture_en = 1'b0;
   logic [61:0] cap_i = '0, cap_q = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // bus slave: samples strobes mid-cycle, acks sl_lat cycles later
   initial begin
      logic [31:0] data, r;
      ack_i = 1'b0;
      rdata_i = '0;
      forever begin
         @(negedge clk_i);
         ack_i = 1'b0;
         if (sl_pend > 0) begin
            sl_pend--;
            if (sl_pend == 0) begin
               ack_i   = 1'b1;
               rdata_i = sl_pend_data;
            end
         end
         if (wen_o || ren_o) begin
            sl_strobes++;
            data = '0;
            if (wen_o) begin
               check("wr_addr", addr_o, 16'h0108);
               wr_log.push_back(wdata_o);
               if (exp_wr.size() == 0) check("unexpected_write", 1, 0);
               else check("wr_freq", wdata_o, exp_wr.pop_front());
               sl_pt = sl_wr_cnt % 32;
               sl_wr_cnt++;
               sl_polls_left = sl_busy[sl_pt];
            end else begin
               r = $urandom();
               case (addr_o)
                  16'h0140: begin
                     if (sl_polls_left > 0) begin
                        data = r | 32'h8000_0000;
                        sl_polls_left--;
                     end else data = sl_regs[sl_pt][0] & 32'h7FFF_FFFF;
                  end
                  16'h0144: data = sl_regs[sl_pt][1];
                  16'h0148: data = sl_regs[sl_pt][2];
                  16'h014C: data = sl_regs[sl_pt][3];
                  default:  check("rd_addr_legal", addr_o, 16'h0140);
               endcase
            end
            if (sl_strobes != sl_mute_at) begin
               sl_pend      = sl_lat;
               sl_pend_data = data;
            end
         end
      end
   end

   initial begin
      res_ready_i = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         case (rdy_mode)
            0:       res_ready_i = 1'b0;
            1:       res_ready_i = 1'($urandom_range(0, 1));
            default: res_ready_i = 1'b1;
         endcase
      end
   end

   // scoreboard monitor
   initial begin
      ent_t e;
      forever begin
         @(negedge clk_i);
         if (done_o) done_cnt++;
         if (res_valid_o && res_ready_i) begin
            pop_cnt++;
            if (exp_q.size() == 0) check("unexpected_pop", res_idx_o, 16'hFFFF);
            else begin
               e = exp_q.pop_front();
               check("res_idx", res_idx_o, e.idx);
               check("res_i", res_i_o, e.i);
               check("res_q", res_q_o, e.q);
            end
            if (capture_en) begin
               cap_i = res_i_o;
               cap_q = res_q_o;
               capture_en = 1'b0;
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic prep(input int maxb);
      for (int p = 0; p < 32; p++) begin
         sl_busy[p] = int'($urandom_range(0, maxb));
         for (int k = 0; k < 4; k++) sl_regs[p][k] = $urandom();
      end
   endtask

   task automatic pulse_start(input logic [31:0] sf, input logic [31:0] st,
                              input logic [15:0] pts, input logic ab);
      @(negedge clk_i);
      start_freq_i = sf;  step_freq_i = st;  points_i = pts;
      start_i = 1'b1;     abort_i = ab;
      @(negedge clk_i);
      start_i = 1'b0;     abort_i = 1'b0;
   endtask

   task automatic go(input logic [31:0] sf, input logic [31:0] st, input int pts,
                     input int n_wr, input int n_ent);
      ent_t e;
      sl_wr_cnt = 0;
      for (int p = 0; p < n_wr; p++) exp_wr.push_back(sf + 32'(p) * st);
      for (int p = 0; p < n_ent; p++) begin
         e.idx = 16'(p);
         e.i   = {sl_regs[p][1][30:0], sl_regs[p][0][30:0]};
         e.q   = {sl_regs[p][3][30:0], sl_regs[p][2][30:0]};
         exp_q.push_back(e);
      end
      pulse_start(sf, st, 16'(pts), 1'b0);
   endtask

   task automatic wait_idle(input string name, input int max);
      int k = 0;
      while (busy_o && k < max) begin
         @(negedge clk_i);
         k++;
      end
      check(name, busy_o, 1'b0);
   endtask

   task automatic drain(input string name, input int max);
      int k = 0;
      while (exp_q.size() != 0 && k < max) begin
         @(negedge clk_i);
         k++;
      end
      check(name, exp_q.size(), 0);
      check({name, "_writes"}, exp_wr.size(), 0);
   endtask

   task automatic wait_rd(input logic [15:0] a, input int max);
      int k = 0;
      do begin
         @(negedge clk_i);
         k++;
      end while (!(ren_o && addr_o == a) && k < max);
      check("wait_rd_seen", ren_o && addr_o == a, 1'b1);
   endtask

   initial begin
      int d0, s0, p0, k, pts;
      rst_i = 1'b1;  start_i = 1'b0;  abort_i = 1'b0;
      start_freq_i = '0;  step_freq_i = '0;  points_i = '0;
      #12;
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_err", err_o, 0);
      check("rst_bus", {wen_o, ren_o, addr_o, wdata_o}, 0);
      check("rst_res", {res_valid_o, res_idx_o, res_i_o, res_q_o}, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // directed sweep: 3 points, two busy polls each, known sums on point 0
      prep(0);
      for (int p = 0; p < 3; p++) sl_busy[p] = 2;
      sl_regs[0][0] = 32'h7FFF_FFFF;  sl_regs[0][1] = 32'h0000_0001;
      sl_regs[0][2] = 32'h0000_0005;  sl_regs[0][3] = 32'h7FFF_FFFF;
      capture_en = 1'b1;
      wr_log.delete();
      d0 = done_cnt;
      go(32'd1000, 32'd500, 3, 3, 3);
      wait_idle("dir_idle", 5000);
      drain("dir_drain", 200);
      check("dir_nwr", wr_log.size(), 3);
      if (wr_log.size() == 3) begin
         check("dir_wr0", wr_log[0], 32'd1000);
         check("dir_wr1", wr_log[1], 32'd1500);
         check("dir_wr2", wr_log[2], 32'd2000);
      end
      check("dir_done", done_cnt - d0, 1);
      check("dir_res_i", cap_i, 62'h0000_0000_FFFF_FFFF);
      check("dir_res_q", cap_q, 62'h3FFF_FFFF_8000_0005);

      // randomized sweeps
      for (int it = 0; it < 4; it++) begin
         pts = int'($urandom_range(1, 8));
         sl_lat = int'($urandom_range(1, 3));
         rdy_mode = 1;
         prep(2);
         d0 = done_cnt;
         go($urandom(), $urandom(), pts, pts, pts);
         wait_idle("rnd_idle", 10000);
         drain("rnd_drain", 500);
         check("rnd_done", done_cnt - d0, 1);
         check("rnd_nwr", sl_wr_cnt, pts);
      end

      // phase wrap
      sl_lat = 1;  rdy_mode = 2;
      prep(1);
      wr_log.delete();
      go(32'hFFFF_FF00, 32'h0000_0200, 2, 2, 2);
      wait_idle("wrap_idle", 3000);
      drain("wrap_drain", 200);
      if (wr_log.size() == 2) check("wrap_wr1", wr_log[1], 32'h0000_0100);
      else check("wrap_nwr", wr_log.size(), 2);

      // FIFO backpressure: 16 entries fill it, PUSH of idx 16 stalls before the 18th write
      rdy_mode = 0;
      prep(1);
      d0 = done_cnt;  p0 = pop_cnt;
      go($urandom(), $urandom(), 20, 20, 20);
      k = 0;
      while (sl_wr_cnt < 17 && k < 5000) begin
         @(negedge clk_i);
         k++;
      end
      repeat (300) @(negedge clk_i);
      check("full_nwr", sl_wr_cnt, 17);
      check("full_busy", busy_o, 1);
      check("full_head", {res_valid_o, res_idx_o}, {1'b1, 16'd0});
      rdy_mode = 1;
      wait_idle("full_idle", 10000);
      drain("full_drain", 500);
      check("full_done", done_cnt - d0, 1);
      check("full_pops", pop_cnt - p0, 20);

      // bus timeout on the third transaction
      rdy_mode = 2;  sl_lat = 1;
      prep(0);
      d0 = done_cnt;
      sl_mute_at = sl_strobes + 3;
      go($urandom(), $urandom(), 2, 1, 0);
      wait_rd(16'h0144, 200);
      k = 0;
      while (!err_o && k < TIMEOUT + 50) begin
         @(negedge clk_i);
         k++;
      end
      check("tmo_cycles", k, TIMEOUT);
      check("tmo_busy", busy_o, 0);
      repeat (5) @(negedge clk_i);
      check("tmo_done", done_cnt - d0, 0);
      sl_mute_at = 0;

      // start with abort in IDLE: ignored, err stays set
      s0 = sl_strobes;
      pulse_start(32'd7, 32'd1, 16'd2, 1'b1);
      repeat (5) @(negedge clk_i);
      check("sa_busy", busy_o, 0);
      check("sa_err", err_o, 1);
      check("sa_strobes", sl_strobes - s0, 0);

      // zero points: done next cycle, err cleared, no bus traffic
      s0 = sl_strobes;  d0 = done_cnt;
      pulse_start(32'd7, 32'd1, 16'd0, 1'b0);
      check("zero_done_pulse", done_o, 1);
      check("zero_err_clr", err_o, 0);
      repeat (10) @(negedge clk_i);
      check("zero_strobes", sl_strobes - s0, 0);
      check("zero_done_once", done_cnt - d0, 1);

      // abort while a poll waits; the late ack is ignored
      sl_lat = 6;
      prep(0);
      d0 = done_cnt;
      go($urandom(), $urandom(), 2, 1, 0);
      wait_rd(16'h0140, 200);
      @(negedge clk_i);
      abort_i = 1'b1;
      @(negedge clk_i);
      abort_i = 1'b0;
      s0 = sl_strobes;
      repeat (20) @(negedge clk_i);
      check("abort_busy", busy_o, 0);
      check("abort_strobes", sl_strobes - s0, 0);
      check("abort_done", done_cnt - d0, 0);
      check("abort_fifo", res_valid_o, 0);

      // asynchronous reset while the 0x148 read is outstanding, one entry in the FIFO
      sl_lat = 3;  rdy_mode = 0;
      prep(0);
      go($urandom(), $urandom(), 2, 2, 0);
      wait_rd(16'h0148, 300);
      wait_rd(16'h0148, 300);
      check("rst_fifo_pre", res_valid_o, 1);
      #2 rst_i = 1'b1;
      #1;
      check("arst_busy", busy_o, 0);
      check("arst_bus", {wen_o, ren_o, addr_o, wdata_o}, 0);
      check("arst_res", {res_valid_o, res_idx_o, res_i_o, res_q_o}, 0);
      check("arst_flags", {done_o, err_o}, 0);
      sl_pend = 0;
      exp_wr.delete();
      exp_q.delete();
      @(negedge clk_i);
      rst_i = 1'b0;
      rdy_mode = 2;
      repeat (10) @(negedge clk_i);
      check("arst_fifo_post", res_valid_o, 0);

      // recovery sweep after reset
      sl_lat = 2;
      prep(1);
      go($urandom(), $urandom(), 2, 2, 2);
      wait_idle("rec_idle", 3000);
      drain("rec_drain", 200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
